// File: rtl/ex_lsu_issue.sv
// Execute-stage issue register and in-order load/store sequencer for an N-wide core.
// Optional macro EX_LSU_ALIGN_CHECK_EN drops misaligned half/word lanes before they issue.
module ex_lsu_issue #(
  parameter int LANES  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OP_W   = 12,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     stall_hold,
  input  logic                     stall_next,
  output logic                     stallreq,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES-1:0]         in_mem_en,
  input  logic [LANES-1:0]         in_mem_wen,
  input  logic [2*LANES-1:0]       in_mem_size,
  input  logic [OP_W*LANES-1:0]    in_mem_op,
  input  logic [ADDR_W*LANES-1:0]  in_base,
  input  logic [ADDR_W*LANES-1:0]  in_offset,
  input  logic [DATA_W*LANES-1:0]  in_wdata,
  output logic [LANES-1:0]         ex_valid,
  output logic [LANES-1:0]         ex_misalign,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic [LW-1:0]            mem_lane,
  output logic                     mem_wen,
  output logic [1:0]               mem_size,
  output logic [OP_W-1:0]          mem_op,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e                        state_q;
  logic [LANES-1:0]              valid_q, misalign_q, pend_q, wen_q;
  logic [LANES-1:0][1:0]         size_q;
  logic [LANES-1:0][OP_W-1:0]    op_q;
  logic [LANES-1:0][ADDR_W-1:0]  addr_q;
  logic [LANES-1:0][DATA_W-1:0]  wdata_q;

  logic [LANES-1:0][ADDR_W-1:0]  eff_addr;
  logic [LANES-1:0]              misal_in, load_pend, pend_d;
  logic [LW-1:0]                 sel_idx;
  logic                          sel_found;
  logic [LW:0]                   pend_cnt;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      eff_addr[l] = in_base[l*ADDR_W +: ADDR_W] + in_offset[l*ADDR_W +: ADDR_W];
    end
  end

`ifdef EX_LSU_ALIGN_CHECK_EN
  // Size 3 behaves as a word access.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      misal_in[l] = in_valid[l] & in_mem_en[l] &
                    (((in_mem_size[2*l +: 2] == 2'd1) & eff_addr[l][0]) |
                     (in_mem_size[2*l+1] & (eff_addr[l][1:0] != 2'b00)));
    end
  end
`else
  assign misal_in = '0;
`endif

  assign load_pend = in_valid & in_mem_en & ~misal_in;

  // Oldest pending lane wins the port; the popcount drives the stall request.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    pend_cnt  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (pend_q[l]) begin
        pend_cnt = pend_cnt + {{LW{1'b0}}, 1'b1};
        if (!sel_found) begin
          sel_idx   = LW'(l);
          sel_found = 1'b1;
        end
      end
    end
  end

  // Request port: a transfer completes on a rising edge with mem_req && mem_ready;
  // while mem_req is high and mem_ready low every mem_* field is held unchanged.
  assign mem_req = (state_q == S_BUSY);

  always_comb begin
    pend_d = pend_q;
    if (mem_req && mem_ready) pend_d[sel_idx] = 1'b0;
  end

  assign stallreq = (pend_cnt >= (LW+1)'(2)) || ((pend_cnt == (LW+1)'(1)) && !mem_ready);

  assign mem_lane    = mem_req ? sel_idx          : '0;
  assign mem_wen     = mem_req ? wen_q[sel_idx]   : 1'b0;
  assign mem_size    = mem_req ? size_q[sel_idx]  : 2'b00;
  assign mem_op      = mem_req ? op_q[sel_idx]    : '0;
  assign mem_addr    = mem_req ? addr_q[sel_idx]  : '0;
  assign mem_wdata   = mem_req ? wdata_q[sel_idx] : '0;
  assign ex_valid    = valid_q;
  assign ex_misalign = misalign_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (!resetn || flush || (stall_hold && !stall_next)) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      misalign_q <= '0;
      pend_q     <= '0;
      wen_q      <= '0;
      size_q     <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (!stall_hold) begin
      state_q    <= (|load_pend) ? S_BUSY : S_IDLE;
      valid_q    <= in_valid;
      misalign_q <= misal_in;
      pend_q     <= load_pend;
      wen_q      <= in_mem_wen;
      size_q     <= in_mem_size;
      op_q       <= in_mem_op;
      addr_q     <= eff_addr;
      wdata_q    <= in_wdata;
    end else begin
      state_q    <= (|pend_d) ? S_BUSY : S_IDLE;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: tb/tb_ex_lsu_issue.sv
// Self-checking bench for ex_lsu_issue: LANES=2 and LANES=4 instances against a
// queue-of-accesses reference model with randomized bundles and ready patterns.
module tb_ex_lsu_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, flush, stall_hold, stall_next, mem_ready, sel4;
  logic [3:0]    in_valid, in_en, in_wen;
  logic [7:0]    in_size;
  logic [47:0]   in_op;
  logic [127:0]  in_base, in_off, in_wd;
  logic [1:0]    v2;
  logic [3:0]    v4;

  assign v2 = sel4 ? 2'b00 : in_valid[1:0];
  assign v4 = sel4 ? in_valid : 4'b0000;

  logic        o2_stallreq, o2_req, o2_wen, o2_dbg;
  logic [1:0]  o2_ex_valid, o2_ex_mis, o2_size;
  logic [0:0]  o2_lane;
  logic [11:0] o2_op;
  logic [31:0] o2_addr, o2_wdata;

  logic        o4_stallreq, o4_req, o4_wen, o4_dbg;
  logic [3:0]  o4_ex_valid, o4_ex_mis;
  logic [1:0]  o4_size, o4_lane;
  logic [11:0] o4_op;
  logic [31:0] o4_addr, o4_wdata;

  ex_lsu_issue #(.LANES(2)) u2 (
    .clk(clk), .resetn(resetn), .flush(flush), .stall_hold(stall_hold), .stall_next(stall_next),
    .stallreq(o2_stallreq), .in_valid(v2), .in_mem_en(in_en[1:0]), .in_mem_wen(in_wen[1:0]),
    .in_mem_size(in_size[3:0]), .in_mem_op(in_op[23:0]), .in_base(in_base[63:0]),
    .in_offset(in_off[63:0]), .in_wdata(in_wd[63:0]), .ex_valid(o2_ex_valid),
    .ex_misalign(o2_ex_mis), .mem_req(o2_req), .mem_ready(mem_ready), .mem_lane(o2_lane),
    .mem_wen(o2_wen), .mem_size(o2_size), .mem_op(o2_op), .mem_addr(o2_addr),
    .mem_wdata(o2_wdata), .dbg_state(o2_dbg));

  ex_lsu_issue #(.LANES(4)) u4 (
    .clk(clk), .resetn(resetn), .flush(flush), .stall_hold(stall_hold), .stall_next(stall_next),
    .stallreq(o4_stallreq), .in_valid(v4), .in_mem_en(in_en), .in_mem_wen(in_wen),
    .in_mem_size(in_size), .in_mem_op(in_op), .in_base(in_base),
    .in_offset(in_off), .in_wdata(in_wd), .ex_valid(o4_ex_valid),
    .ex_misalign(o4_ex_mis), .mem_req(o4_req), .mem_ready(mem_ready), .mem_lane(o4_lane),
    .mem_wen(o4_wen), .mem_size(o4_size), .mem_op(o4_op), .mem_addr(o4_addr),
    .mem_wdata(o4_wdata), .dbg_state(o4_dbg));

  logic        ob_stallreq, ob_req, ob_wen, ob_dbg;
  logic [3:0]  ob_ex_valid, ob_ex_mis;
  logic [1:0]  ob_size, ob_lane;
  logic [11:0] ob_op;
  logic [31:0] ob_addr, ob_wdata;

  assign ob_stallreq = sel4 ? o4_stallreq : o2_stallreq;
  assign ob_req      = sel4 ? o4_req      : o2_req;
  assign ob_wen      = sel4 ? o4_wen      : o2_wen;
  assign ob_dbg      = sel4 ? o4_dbg      : o2_dbg;
  assign ob_ex_valid = sel4 ? o4_ex_valid : {2'b00, o2_ex_valid};
  assign ob_ex_mis   = sel4 ? o4_ex_mis   : {2'b00, o2_ex_mis};
  assign ob_size     = sel4 ? o4_size     : o2_size;
  assign ob_lane     = sel4 ? o4_lane     : {1'b0, o2_lane};
  assign ob_op       = sel4 ? o4_op       : o2_op;
  assign ob_addr     = sel4 ? o4_addr     : o2_addr;
  assign ob_wdata    = sel4 ? o4_wdata    : o2_wdata;

  int checks = 0;
  int failures = 0;
  int nl = 2;
  logic [80:0] exp_q[$];
  logic [3:0]  exp_valid, exp_mis;

  // The pipeline controller must never load this stage while it asks to stall.
  always @(posedge clk) begin
    if (resetn && !flush && !stall_hold) begin
      checks++;
      if (ob_stallreq) begin
        failures++;
        $display("FAIL load_while_stallreq: stallreq=%b at load, required 0", ob_stallreq);
      end
    end
  end

  function automatic logic [80:0] pack_obs();
    return {ob_lane, ob_wen, ob_size, ob_op, ob_addr, ob_wdata};
  endfunction

  task automatic clear_inputs();
    in_valid = '0; in_en = '0; in_wen = '0; in_size = '0; in_op = '0;
    in_base = '0; in_off = '0; in_wd = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic en, input logic wen,
                          input logic [1:0] sz, input logic [11:0] op,
                          input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
    in_valid[l] = v; in_en[l] = en; in_wen[l] = wen; in_size[2*l +: 2] = sz;
    in_op[12*l +: 12] = op; in_base[32*l +: 32] = base; in_off[32*l +: 32] = off;
    in_wd[32*l +: 32] = wd;
  endtask

  // Reference model: the bundle becomes an ordered list of accesses, oldest lane first.
  task automatic build_expected();
    exp_valid = '0;
    exp_mis = '0;
    for (int l = 0; l < nl; l++) begin
      logic [31:0] a;
      logic [1:0]  sz, lb;
      logic        mis;
      a  = in_base[32*l +: 32] + in_off[32*l +: 32];
      sz = in_size[2*l +: 2];
      lb = l[1:0];
      mis = 1'b0;
`ifdef EX_LSU_ALIGN_CHECK_EN
      if (in_valid[l] && in_en[l]) begin
        if (sz == 2'd1 && (a % 2) != 0) mis = 1'b1;
        if (sz >= 2'd2 && (a % 4) != 0) mis = 1'b1;
      end
`endif
      exp_valid[l] = in_valid[l];
      exp_mis[l] = mis;
      if (in_valid[l] && in_en[l] && !mis)
        exp_q.push_back({lb, in_wen[l], sz, in_op[12*l +: 12], a, in_wd[32*l +: 32]});
    end
  endtask

  task automatic load_bundle(input string name);
    build_expected();
    stall_hold = 1'b0; stall_next = 1'b0;
    @(posedge clk); #1;
    stall_hold = 1'b1; stall_next = 1'b1;
    clear_inputs();
    checks += 2;
    if (ob_ex_valid !== exp_valid) begin
      failures++;
      $display("FAIL %s_ex_valid: got %b, required %b", name, ob_ex_valid, exp_valid);
    end
    if (ob_ex_mis !== exp_mis) begin
      failures++;
      $display("FAIL %s_ex_misalign: got %b, required %b", name, ob_ex_mis, exp_mis);
    end
  endtask

  // mode 0: mem_ready follows pat bit per cycle; mode 1: random mem_ready.
  task automatic drain(input string name, input int mode, input logic [31:0] pat,
                       output int cyc, output int stalls);
    int i;
    i = 0; cyc = 0; stalls = 0;
    while (exp_q.size() > 0 && i < 64) begin
      logic rdy, exp_st;
      rdy = (mode == 0) ? ((i < 32) ? pat[i] : 1'b1) : ($urandom_range(0, 2) != 0);
      mem_ready = rdy;
      #1;
      exp_st = (exp_q.size() >= 2) || !rdy;
      checks += 3;
      if (ob_req !== 1'b1) begin
        failures++;
        $display("FAIL %s_req cycle %0d: got %b, required 1", name, i, ob_req);
      end
      if (pack_obs() !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_fields cycle %0d: got %h, required %h", name, i, pack_obs(), exp_q[0]);
      end
      if (ob_stallreq !== exp_st) begin
        failures++;
        $display("FAIL %s_stallreq cycle %0d: got %b, required %b", name, i, ob_stallreq, exp_st);
      end
      if (ob_stallreq === 1'b1) stalls++;
      cyc++;
      @(posedge clk); #1;
      if (rdy) void'(exp_q.pop_front());
      i++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d accesses left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ob_req !== 1'b0 || ob_stallreq !== 1'b0 || ob_dbg !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: req=%b stallreq=%b state=%b, required 0 0 0", name, ob_req, ob_stallreq, ob_dbg);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; stall_hold = 1'b0; stall_next = 1'b0;
    sel4 = 1'b0; mem_ready = 1'b0;
    for (int l = 0; l < 4; l++)
      set_lane(l, 1'b1, 1'b1, 1'($urandom), 2'($urandom), 12'($urandom), $urandom, $urandom, $urandom);
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (o2_ex_valid !== 2'b00 || o4_ex_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_ex_valid: got %b %b, required 0", o2_ex_valid, o4_ex_valid);
    end
    if (o2_req !== 1'b0 || o4_req !== 1'b0) begin
      failures++; $display("FAIL reset_mem_req: got %b %b, required 0", o2_req, o4_req);
    end
    if (o2_stallreq !== 1'b0 || o4_stallreq !== 1'b0) begin
      failures++; $display("FAIL reset_stallreq: got %b %b, required 0", o2_stallreq, o4_stallreq);
    end
    if (o2_addr !== 32'h0 || o4_addr !== 32'h0 || o2_wdata !== 32'h0 || o4_op !== 12'h0) begin
      failures++; $display("FAIL reset_fields: got %h %h, required 0", o2_addr, o4_addr);
    end
    if (o2_ex_mis !== 2'b00 || o4_ex_mis !== 4'b0000 || o4_lane !== 2'b00) begin
      failures++; $display("FAIL reset_misalign_lane: got %b %b %b, required 0", o2_ex_mis, o4_ex_mis, o4_lane);
    end
    if (o2_dbg !== 1'b0 || o4_dbg !== 1'b0) begin
      failures++; $display("FAIL reset_state: got %b %b, required idle", o2_dbg, o4_dbg);
    end
    clear_inputs();
    stall_hold = 1'b1; stall_next = 1'b1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_load();
    int cyc, st;
    sel4 = 1'b0; nl = 2;
    clear_inputs();
    set_lane(0, 1'b1, 1'b1, 1'b0, 2'd2, 12'h021, 32'h1000, 32'h4, 32'h0);
    set_lane(1, 1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 32'h55, 32'h66, 32'h0);
    load_bundle("single");
    checks += 2;
    if (ob_addr !== 32'h1004) begin
      failures++; $display("FAIL single_addr: got %h, required 00001004", ob_addr);
    end
    if (ob_lane !== 2'd0) begin
      failures++; $display("FAIL single_lane: got %0d, required 0", ob_lane);
    end
    drain("single", 0, 32'hFFFF_FFFF, cyc, st);
    checks += 2;
    if (cyc != 1) begin failures++; $display("FAIL single_cycles: got %0d, required 1", cyc); end
    if (st != 0) begin failures++; $display("FAIL single_stalls: got %0d, required 0", st); end
  endtask

  task automatic test_two_stores();
    int cyc, st;
    sel4 = 1'b0; nl = 2;
    clear_inputs();
    set_lane(0, 1'b1, 1'b1, 1'b1, 2'd2, 12'h105, 32'h2000, 32'h10, 32'hDEAD_BEEF);
    set_lane(1, 1'b1, 1'b1, 1'b1, 2'd1, 12'h106, 32'h3000, 32'h2, 32'h0000_1234);
    load_bundle("stores");
    drain("stores", 0, 32'hFFFF_FFFF, cyc, st);
    checks += 2;
    if (cyc != 2) begin failures++; $display("FAIL stores_cycles: got %0d, required 2", cyc); end
    if (st != 1) begin failures++; $display("FAIL stores_stalls: got %0d, required 1", st); end
  endtask

  task automatic test_lanes4_wait();
    int cyc, st;
    sel4 = 1'b1; nl = 4;
    clear_inputs();
    set_lane(0, 1'b1, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 32'h0);
    set_lane(1, 1'b1, 1'b1, 1'b0, 2'd2, 12'h201, 32'h4000, 32'h8, 32'h0);
    set_lane(2, 1'b1, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 32'h0);
    set_lane(3, 1'b1, 1'b1, 1'b0, 2'd2, 12'h203, 32'h5000, 32'hC, 32'h0);
    load_bundle("lanes4");
    drain("lanes4", 0, 32'hFFFF_FFFC, cyc, st);
    checks += 2;
    if (cyc != 4) begin failures++; $display("FAIL lanes4_cycles: got %0d, required 4", cyc); end
    if (st != 3) begin failures++; $display("FAIL lanes4_stalls: got %0d, required 3", st); end
  endtask

  task automatic test_flush();
    sel4 = 1'b0; nl = 2;
    clear_inputs();
    set_lane(0, 1'b1, 1'b1, 1'b1, 2'd2, 12'h301, 32'h6000, 32'h0, 32'h1111_1111);
    set_lane(1, 1'b1, 1'b1, 1'b1, 2'd2, 12'h302, 32'h6004, 32'h0, 32'h2222_2222);
    load_bundle("flush");
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ob_req !== 1'b1) begin failures++; $display("FAIL flush_busy: got %b, required 1", ob_req); end
    flush = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mem_ready = 1'b0;
    exp_q.delete();
    #1;
    checks += 3;
    if (ob_req !== 1'b0) begin failures++; $display("FAIL flush_req: got %b, required 0", ob_req); end
    if (ob_ex_valid !== 4'b0) begin failures++; $display("FAIL flush_ex_valid: got %b, required 0", ob_ex_valid); end
    if (ob_stallreq !== 1'b0 || ob_dbg !== 1'b0) begin
      failures++; $display("FAIL flush_state: stallreq=%b state=%b, required 0 0", ob_stallreq, ob_dbg);
    end
  endtask

  task automatic test_bubble_hold();
    sel4 = 1'b0; nl = 2;
    clear_inputs();
    set_lane(0, 1'b1, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 32'h0);
    set_lane(1, 1'b1, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 32'h0);
    load_bundle("bubble");
    set_lane(0, 1'b1, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 32'h0);
    stall_hold = 1'b1; stall_next = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ob_ex_valid !== 4'b0011) begin failures++; $display("FAIL hold_ex_valid: got %b, required 0011", ob_ex_valid); end
    stall_next = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ob_ex_valid !== 4'b0000) begin failures++; $display("FAIL bubble_ex_valid: got %b, required 0000", ob_ex_valid); end
    stall_next = 1'b1;
    clear_inputs();
  endtask

  task automatic test_misalign();
    int cyc, st;
    sel4 = 1'b0; nl = 2;
    clear_inputs();
    set_lane(0, 1'b1, 1'b1, 1'b0, 2'd1, 12'h401, 32'h1000, 32'h1, 32'h0);
    load_bundle("misalign");
    checks += 2;
`ifdef EX_LSU_ALIGN_CHECK_EN
    if (ob_ex_mis !== 4'b0001) begin failures++; $display("FAIL misalign_flag: got %b, required 0001", ob_ex_mis); end
    if (ob_req !== 1'b0) begin failures++; $display("FAIL misalign_req: got %b, required 0", ob_req); end
`else
    if (ob_req !== 1'b1) begin failures++; $display("FAIL misalign_req: got %b, required 1", ob_req); end
    if (ob_addr !== 32'h1001) begin failures++; $display("FAIL misalign_addr: got %h, required 00001001", ob_addr); end
`endif
    drain("misalign", 0, 32'hFFFF_FFFF, cyc, st);
  endtask

  task automatic test_back_to_back();
    int cyc, st;
    sel4 = 1'b0; nl = 2;
    clear_inputs();
    set_lane(0, 1'b1, 1'b1, 1'b1, 2'd2, 12'h501, 32'h7000, 32'h0, 32'hAAAA_0000);
    set_lane(1, 1'b1, 1'b1, 1'b1, 2'd0, 12'h502, 32'h7003, 32'h0, 32'h0000_00BB);
    load_bundle("b2b_a");
    mem_ready = 1'b1;
    #1;
    checks += 2;
    if (pack_obs() !== exp_q[0]) begin failures++; $display("FAIL b2b_first: got %h, required %h", pack_obs(), exp_q[0]); end
    if (ob_stallreq !== 1'b1) begin failures++; $display("FAIL b2b_stall1: got %b, required 1", ob_stallreq); end
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    checks += 2;
    if (pack_obs() !== exp_q[0]) begin failures++; $display("FAIL b2b_second: got %h, required %h", pack_obs(), exp_q[0]); end
    if (ob_stallreq !== 1'b0) begin failures++; $display("FAIL b2b_stall2: got %b, required 0", ob_stallreq); end
    void'(exp_q.pop_front());
    set_lane(0, 1'b1, 1'b1, 1'b0, 2'd2, 12'h511, 32'h8000, 32'h20, 32'h0);
    set_lane(1, 1'b1, 1'b1, 1'b0, 2'd2, 12'h512, 32'h8000, 32'h24, 32'h0);
    load_bundle("b2b_b");
    drain("b2b_b", 0, 32'hFFFF_FFFF, cyc, st);
    checks++;
    if (cyc != 2) begin failures++; $display("FAIL b2b_cycles: got %0d, required 2", cyc); end
  endtask

  task automatic test_random();
    int cyc, st;
    repeat (40) begin
      sel4 = 1'($urandom_range(0, 1));
      nl = sel4 ? 4 : 2;
      clear_inputs();
      for (int l = 0; l < nl; l++)
        set_lane(l, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 12'($urandom),
                 $urandom, 32'($urandom_range(0, 7)), $urandom);
      load_bundle("random");
      drain("random", 1, 32'h0, cyc, st);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_load();
    test_two_stores();
    test_lanes4_wait();
    test_flush();
    test_bubble_hold();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_lsu_issue.md
# ex_lsu_issue

Parametrised execute-stage issue register and load/store sequencer for the N-wide in-order core, generalising the dual-issue EX stage. Captures an ID→EX bundle of `LANES` instructions with the standard stall/flush bubble rules and computes each lane's effective address. It serialises every memory-accessing lane onto the single data-SRAM request port in program order, stalling the pipeline only while more than one access remains. It sits between the ID/EX boundary and the dcache/data-SRAM request interface.

## Interface
- `LANES`, 2, issue width; lane 0 is oldest.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, store data width.
- `OP_W`, 12, memory op code width, passed through unmodified.
- `clk`  input  1  clock; all state changes on the rising edge.
- `resetn`  input  1  synchronous, active-low reset.
- `flush`  input  1  discard the captured bundle and all pending accesses.
- `stall_hold`  input  1  this stage is stopped (stall bit 3).
- `stall_next`  input  1  the MEM stage is stopped (stall bit 4).
- `stallreq`  output  1  request to stop this stage.
- `in_valid`  input  LANES  per-lane instruction valid.
- `in_mem_en`, `in_mem_wen`  input  LANES  per-lane memory access and write.
- `in_mem_size`  input  2*LANES  per-lane size: 0 byte, 1 half, 2 word; 3 is treated as word.
- `in_mem_op`  input  OP_W*LANES  per-lane op code.
- `in_base`, `in_offset`  input  ADDR_W*LANES  address operands.
- `in_wdata`  input  DATA_W*LANES  store data.
- `ex_valid`  output  LANES  registered lane valid.
- `ex_misalign`  output  LANES  registered misalignment flag.
- `mem_req`  output  1  access request.
- `mem_ready`  input  1  access accepted.
- `mem_lane`  output  $clog2(LANES) (minimum 1)  index of the lane being issued.
- `mem_wen`  output  1  write access.
- `mem_size`  output  2  access size.
- `mem_op`  output  OP_W  op code.
- `mem_addr`  output  ADDR_W  effective address.
- `mem_wdata`  output  DATA_W  store data.

## Operation
- Capture register update, in priority order:
  1. `!resetn` or `flush` → clear to all zeros.
  2. `stall_hold && !stall_next` → clear (bubble).
  3. `!stall_hold` → load the inputs.
  4. Otherwise → hold.
- Effective address per lane: `base + offset`, modulo 2^ADDR_W; carry is discarded.
- Pending mask `P[LANES]` is a register.
  - Cleared by every clear case above.
  - On load: `P = in_valid & in_mem_en & ~misalign`.
- State machine:
  - IDLE when `P == 0`.
  - BUSY when `P != 0`.
  - IDLE → BUSY on a load with any bit set in `P`.
  - BUSY → IDLE when the last pending bit is accepted, or on flush/reset.
- In BUSY, `mem_req = 1`. The selected lane is the lowest set bit of `P`; all `mem_*` fields come from that lane.
- Handshake: a transfer completes on an edge where `mem_req && mem_ready`. The selected bit of `P` clears on that edge.
  - `mem_*` outputs are held stable while `mem_req && !mem_ready`.
- `stallreq = (popcount(P) >= 2) || (popcount(P) == 1 && !mem_ready)`.
- Flush in the same cycle as an accepted transfer: the transfer counts as issued externally, and all internal state clears.
- A load while `P != 0` is illegal, because the pipeline controller holds this stage on `stallreq`. The bench asserts that it never happens.
- Reset values: all outputs 0, and the state machine is in IDLE.

## Timing
- A bundle captured at edge N presents `mem_req` during cycle N+1 with no added latency. Request fields are combinational from registers only.
- `stallreq` is combinational on `mem_ready`; there is no other input-to-output path.
- K accesses with `mem_ready` held high take K cycles. `stallreq` is high for the first K-1 of them.
- A single access with `mem_ready` high causes zero stall cycles.
- Each cycle of `mem_ready` low adds one stall cycle.

## Configuration
- `EX_LSU_ALIGN_CHECK_EN` defined:
  - A lane is misaligned when it is a half access with `addr[0] = 1`, or a word access with `addr[1:0] != 0`.
  - Misaligned lanes are excluded from `P` at load, so they are never issued.
  - `ex_misalign` is registered with the bundle.
- `EX_LSU_ALIGN_CHECK_EN` undefined:
  - `ex_misalign` is tied to 0.
  - All `in_mem_en` lanes are issued unchecked.

## Test plan
- LANES=2, lane0 load word with base 0x1000 and offset 0x4, lane1 ALU, ready high → one req: `mem_addr = 0x1004`, `mem_lane = 0`, `stallreq` never high.
- LANES=2, both lanes stores, ready high:
  - cycle 1: lane0 request, `stallreq = 1`;
  - cycle 2: lane1 request, `stallreq = 0`;
  - then IDLE.
- LANES=4, lanes 1 and 3 loads, ready low for 2 cycles then high:
  - lane1 request held stable for 3 cycles, then lane3 issues;
  - `stallreq` is high for 3 cycles.
- Flush while BUSY with two lanes pending → `P` cleared next edge, `mem_req = 0`, `ex_valid = 0`.
- `stall_hold = 1` and `stall_next = 0` with a valid input → `ex_valid = 0` after the edge. With `stall_hold = 1` and `stall_next = 1`, the register holds its value.
- With the macro defined: half access at addr 0x1001 → `ex_misalign[0] = 1`, no `mem_req`. Without the macro, the same access is issued at 0x1001.
